// File: rtl/mul_div_pkg.sv
// Shared encodings, FSM states and constants for the iterative RV32M multiply/divide unit.
// Not a module, so no latency or backpressure behaviour of its own.
package mul_div_pkg;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    localparam int          ITER_COUNT    = 32;
    localparam int          CNT_W         = 5;
    localparam logic [31:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN       = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/mul_div_step.sv
// One radix-2 iteration: shift-add on {hi, multiplier} or restoring subtract on {rem, quot}.
// Purely combinational, zero latency; no handshake, so no backpressure.
module mul_div_step
    import mul_div_pkg::*;
(
    input  logic        is_div_i,
    input  logic [63:0] acc_i,
    input  logic [31:0] opnd_i,
    output logic [63:0] acc_o
);

    logic [32:0] mul_sum;
    logic [32:0] rem_sh;
    logic        no_borrow;
    logic [31:0] rem_new;

    // Right-shifting product: low half starts as the multiplier and drains one bit per step.
    assign mul_sum   = {1'b0, acc_i[63:32]} + (acc_i[0] ? {1'b0, opnd_i} : 33'd0);

    // Partial remainder stays below the divisor, so a 32-bit difference is exact.
    assign rem_sh    = {acc_i[63:32], acc_i[31]};
    assign no_borrow = (rem_sh >= {1'b0, opnd_i});
    assign rem_new   = no_borrow ? (rem_sh[31:0] - opnd_i) : rem_sh[31:0];

    assign acc_o = is_div_i ? {rem_new, acc_i[30:0], no_borrow}
                            : {mul_sum, acc_i[31:1]};

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide: 33 cycles accept-to-result, 1 cycle for div-by-zero/overflow.
// in_ready only in IDLE; the result is held in DONE until out_ready; flush aborts from any state.
module mul_div_unit
    import mul_div_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

    if (XLEN != 32) begin : g_bad_xlen
        $error("mul_div_unit: only XLEN=32 is supported");
    end

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                fix_q, fix_d;
    logic [2:0]          op_q, op_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]     opnd_q, opnd_d;
    logic                neg_q, neg_d;
    logic                rneg_q, rneg_d;
    logic [XLEN-1:0]     result_q, result_d;

    logic              in_is_div, a_sgn, b_sgn, div_zero, div_ovf;
    logic [XLEN-1:0]   a_mag, b_mag, quot_fix, rem_fix, final_res;
    logic [2*XLEN-1:0] acc_step, prod_fix;

    assign in_is_div = op[2];
    assign a_sgn     = (in_is_div ? !op[0] : (op != OP_MULHU)) & a[XLEN-1];
    assign b_sgn     = (in_is_div ? !op[0] : (op == OP_MUL || op == OP_MULH)) & b[XLEN-1];
    assign a_mag     = cond_neg(a, a_sgn);
    assign b_mag     = cond_neg(b, b_sgn);
    assign div_zero  = in_is_div && (b == '0);
    assign div_ovf   = in_is_div && !op[0] && (a == INT_MIN) && (b == '1);

    mul_div_step u_step (
        .is_div_i (op_q[2]),
        .acc_i    (acc_q),
        .opnd_i   (opnd_q),
        .acc_o    (acc_step)
    );

    assign prod_fix  = neg_q ? (~acc_q + 64'd1) : acc_q;
    assign quot_fix  = cond_neg(acc_q[XLEN-1:0], neg_q);
    assign rem_fix   = cond_neg(acc_q[2*XLEN-1:XLEN], rneg_q);
    assign final_res = op_q[2] ? (op_q[1] ? rem_fix : quot_fix)
                               : ((op_q == OP_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN]);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        fix_d    = fix_q;
        op_d     = op_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        result_d = result_q;
        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
            fix_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        op_d   = op;
                        acc_d  = {{XLEN{1'b0}}, (in_is_div ? a_mag : b_mag)};
                        opnd_d = in_is_div ? b_mag : a_mag;
                        neg_d  = a_sgn ^ b_sgn;
                        rneg_d = a_sgn;
                        fix_d  = 1'b0;
                        if (div_zero) begin
                            result_d = op[1] ? a : DIV_ZERO_QUOT;
                            state_d  = DONE;
                        end else if (div_ovf) begin
                            result_d = op[1] ? '0 : INT_MIN;
                            state_d  = DONE;
                        end else begin
                            cnt_d   = CNT_W'(ITER_COUNT - 1);
                            state_d = CALC;
                        end
                    end
                end
                CALC: begin
                    // The extra cycle after the last iteration applies the sign fix-up.
                    if (fix_q) begin
                        result_d = final_res;
                        fix_d    = 1'b0;
                        state_d  = DONE;
                    end else begin
                        acc_d = acc_step;
                        if (cnt_q == '0) begin
                            fix_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q - 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            fix_q    <= 1'b0;
            op_q     <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            fix_q    <= fix_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            result_q <= result_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed-vector bench for mul_div_unit: latency, results, fast paths, backpressure, reset and flush abort.
module tb_mul_div_unit;
    import mul_div_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    mul_div_unit #(.XLEN(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Presents a request for one edge; caller guarantees the unit is idle.
    task automatic issue(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
        in_valid = 1'b1;
        op = o;
        a = av;
        b = bv;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op = 3'd7;
        a = 32'hDEAD_BEEF;
        b = 32'h0BAD_F00D;
    endtask

    task automatic wait_done(input string tag, input logic [31:0] exp, input int lat);
        int n = 0;
        logic busy_ok = 1'b1;
        do begin
            if (in_ready) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            n++;
            if (in_ready) busy_ok = 1'b0;
        end while (!out_valid && n < 100);
        chk({tag, "_lat"}, 32'(n), 32'(lat));
        chk({tag, "_res"}, result, exp);
        chk({tag, "_busy"}, {31'd0, busy_ok}, 32'd1);
    endtask

    task automatic take(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "_ovl0"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_rdy1"}, {31'd0, in_ready}, 32'd1);
    endtask

    task automatic run(input string tag, input logic [2:0] o, input logic [31:0] av,
                       input logic [31:0] bv, input logic [31:0] exp, input int lat);
        issue(o, av, bv);
        wait_done(tag, exp, lat);
        take(tag);
    endtask

    initial begin
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_result", result, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run("mul_7x6", OP_MUL, 32'd7, 32'd6, 32'h0000_002A, 33);
        run("mulh_min", OP_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
        run("mulhu_max", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        run("mulhsu", OP_MULHSU, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 33);
        run("mul_neg", OP_MUL, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 33);
        run("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        run("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        run("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'h0000_000E, 33);
        run("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'h0000_0002, 33);
        run("div_5_0", OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        run("rem_5_0", OP_REM, 32'd5, 32'd0, 32'h0000_0005, 1);
        run("divu_5_0", OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        run("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);
        run("divu_big", OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 33);

        // Backpressure: result held while out_ready stays low.
        issue(OP_DIVU, 32'd1000, 32'd3);
        wait_done("bp", 32'd333, 33);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_hold_ovl", {31'd0, out_valid}, 32'd1);
            chk("bp_hold_res", result, 32'd333);
            chk("bp_hold_rdy", {31'd0, in_ready}, 32'd0);
        end
        take("bp_take");
        run("bp_next", OP_REMU, 32'd1000, 32'd3, 32'd1, 33);

        // Asynchronous reset in the middle of a divide.
        issue(OP_DIVU, 32'd100, 32'd7);
        repeat (9) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_ovl", {31'd0, out_valid}, 32'd0);
        chk("arst_rdy", {31'd0, in_ready}, 32'd1);
        chk("arst_res", result, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run("post_rst", OP_DIVU, 32'd100, 32'd7, 32'h0000_000E, 33);

        // Flush in the middle of an operation.
        issue(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_rdy", {31'd0, in_ready}, 32'd1);
        begin
            logic seen = 1'b0;
            for (int i = 0; i < 40; i++) begin
                @(posedge clk);
                #1;
                if (out_valid) seen = 1'b1;
            end
            chk("flush_no_ovl", {31'd0, seen}, 32'd0);
        end

        // Flush together with a request: nothing accepted.
        in_valid = 1'b1;
        flush = 1'b1;
        op = OP_DIV;
        a = 32'd5;
        b = 32'd0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush = 1'b0;
        chk("flush_acc_rdy", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        chk("flush_acc_ovl", {31'd0, out_valid}, 32'd0);

        // Flush discards a result sitting in DONE.
        issue(OP_REM, 32'd9, 32'd0);
        chk("flush_done_ovl1", {31'd0, out_valid}, 32'd1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_done_ovl0", {31'd0, out_valid}, 32'd0);
        run("post_flush", OP_MUL, 32'd12345, 32'd1000, 32'd12345000, 33);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative RV32M multiply/divide unit.
- Sits beside the ALU and consumes the same operand pair the ALU input muxes produce: operand a from the rs1 path, operand b from the rs2/immediate path.
- Accepts one operation through a valid/ready handshake and runs a radix-2 shift-add or restoring-divide loop over 32 cycles.
- Returns a 32-bit result through a second valid/ready handshake. Exactly one operation is in flight at a time.

Parameters:
- XLEN, 32, operand and result width. Only 32 is supported; any other value is an elaboration error.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  abort any in-flight operation (pipeline redirect).
- in_valid  in  1  operation request.
- in_ready  out  1  unit idle; accepts a request this cycle.
- op  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- a  in  XLEN  operand rs1.
- b  in  XLEN  operand rs2.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- result  out  XLEN  registered result.

Behaviour:
- Reset: state=IDLE, in_ready=1, out_valid=0, result=0, counter=0, all datapath registers 0.
- Asserting rst_n low mid-operation clears everything immediately (asynchronous).
- States:
  - IDLE: in_ready=1. On in_valid&&!flush, latch op, operand magnitudes and result sign, then go to CALC with counter=31.
  - CALC: in_ready=0, out_valid=0. One iteration per cycle; counter decrements. At counter==0, apply sign correction, register result, go to DONE.
  - DONE: out_valid=1, result held stable. On out_ready go to IDLE; in_ready=1 in the following cycle. There is no same-cycle back-to-back accept.
- Latency: a request accepted at edge E0 gives out_valid high after edge E33 (32 CALC cycles plus 1).
- Fast path, skipping CALC (out_valid high after E1):
  - divide by zero (b==0, op[2]=1): DIV/DIVU result 0xFFFFFFFF; REM/REMU result a.
  - signed overflow (DIV/REM, a==0x80000000, b==0xFFFFFFFF): DIV result 0x80000000; REM result 0.
- Multiply:
  - Unsigned shift-add on magnitudes into a 64-bit product register.
  - An operand is treated as signed for MUL/MULH (a and b) and for MULHSU (a only). MULHU treats both as unsigned.
  - Product sign = XOR of the signs of the operands treated as signed. If set, the 64-bit product is two's-complement negated before selection.
  - MUL returns product[31:0]; all other multiply ops return product[63:32].
- Divide:
  - Restoring division on magnitudes: each iteration shifts the remainder left by 1, trial-subtracts the divisor, and sets the quotient bit on no borrow.
  - Signed quotient sign = a_sign XOR b_sign; remainder sign = a_sign.
  - Result magnitudes are negated per sign at finalisation.
- flush: highest priority below reset. In any state, force IDLE next cycle with out_valid=0. A result in DONE is discarded. flush together with in_valid in IDLE means no accept.
- in_valid while busy is ignored; the requester must hold the request until it sees in_ready.
- Changes to op, a and b after accept have no effect.

Decomposition:
- Shared package mul_div_pkg:
  - op encodings as named 3-bit constants (OP_MUL … OP_REMU).
  - state enum (IDLE, CALC, DONE).
  - constants ITER_COUNT=32, DIV_ZERO_QUOT=32'hFFFFFFFF, INT_MIN=32'h80000000.
- One sub-module, mul_div_step: purely combinational single-iteration datapath (add-shift for multiply, subtract-shift for divide) selected by op[2]. The top level holds the FSM, counter, operand registers and sign fix-up.

Test Plan:
- MUL a=7, b=6 accepted at cycle 0 -> out_valid at cycle 33, result=0x0000002A; in_ready=0 on cycles 1..33.
- MULH 0x80000000×0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE; MULHSU a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 0x0000000E; REMU 100/7 -> 0x00000002.
- DIV 5/0 -> 0xFFFFFFFF and REM 5/0 -> 0x00000005, out_valid at cycle 1. DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM -> 0, at cycle 1.
- Backpressure: out_ready held low 5 cycles in DONE -> result and out_valid stable, in_ready=0. Then out_ready=1 -> out_valid=0 and in_ready=1 next cycle; a new in_valid is accepted then.
- Abort: rst_n pulsed low at cycle 10 of a DIVU -> out_valid=0 and in_ready=1 immediately. Separately, flush at cycle 10 -> IDLE next cycle, no out_valid ever, next op computes correctly.
